// File: rtl/toy_inst_fetch.sv
// Instruction-fetch initiator: owns the fetch PC, issues 1-cycle memory reads and
// pairs each returned word with its PC in a small FIFO presented to the decoder.
module toy_inst_fetch #(
    parameter int unsigned              ADDR_WIDTH = 32,
    parameter int unsigned              DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]    RESET_PC   = '0,
    parameter int unsigned              BUF_DEPTH  = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    output logic                        mem_en,
    output logic [ADDR_WIDTH-1:0]       mem_addr,
    input  logic [DATA_WIDTH-1:0]       mem_rd_data,
    output logic [DATA_WIDTH-1:0]       mem_wr_data,
    output logic [DATA_WIDTH/8-1:0]     mem_wr_byte_en,
    output logic                        mem_wr_en,
    input  logic                        redirect_vld,
    input  logic [ADDR_WIDTH-1:0]       redirect_pc,
    output logic                        inst_vld,
    input  logic                        inst_rdy,
    output logic [ADDR_WIDTH-1:0]       inst_pc,
    output logic [DATA_WIDTH-1:0]       inst_data
);

    localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic                  inflight_q, inflight_d;
    logic [ADDR_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
    logic [ADDR_WIDTH-1:0] pc_mem_q [BUF_DEPTH];
    logic [ADDR_WIDTH-1:0] pc_mem_d [BUF_DEPTH];
    logic [DATA_WIDTH-1:0] data_mem_q [BUF_DEPTH];
    logic [DATA_WIDTH-1:0] data_mem_d [BUF_DEPTH];
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;

    logic                  pop;
    logic                  push;
    logic                  issue;
    logic [CNT_W-1:0]      occupancy;
    logic                  unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // Occupancy counts the in-flight word too, so an issue never outruns free space.
    always_comb begin
        pop       = inst_vld & inst_rdy & ~redirect_vld;
        push      = inflight_q & ~redirect_vld;
        occupancy = count_q + CNT_W'(inflight_q);
        issue     = ~rst & ~redirect_vld & ((occupancy - CNT_W'(pop)) < CNT_W'(BUF_DEPTH));
    end

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = issue;
        inflight_pc_d = inflight_pc_q;
        pc_mem_d      = pc_mem_q;
        data_mem_d    = data_mem_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q + CNT_W'(push) - CNT_W'(pop);

        if (issue) begin
            inflight_pc_d = fetch_pc_q;
            fetch_pc_d    = fetch_pc_q + ADDR_WIDTH'(4);
        end

        if (push) begin
            pc_mem_d[wr_ptr_q]   = inflight_pc_q;
            data_mem_d[wr_ptr_q] = mem_rd_data;
            wr_ptr_d             = wr_ptr_q + PTR_W'(1);
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        // Redirect drops the buffer and the word returning this cycle.
        if (redirect_vld) begin
            fetch_pc_d = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
            inflight_d = 1'b0;
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                pc_mem_q[i]   <= '0;
                data_mem_q[i] <= '0;
            end
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            pc_mem_q      <= pc_mem_d;
            data_mem_q    <= data_mem_d;
        end
    end

    assign mem_en         = issue;
    assign mem_addr       = {2'b00, fetch_pc_q[ADDR_WIDTH-1:2]};
    assign mem_wr_data    = '0;
    assign mem_wr_byte_en = '0;
    assign mem_wr_en      = 1'b0;

    assign inst_vld  = (count_q != '0);
    assign inst_pc   = pc_mem_q[rd_ptr_q];
    assign inst_data = data_mem_q[rd_ptr_q];

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && (count_q == CNT_W'(BUF_DEPTH))));

endmodule

// File: tb/tb_toy_inst_fetch.sv
// Self-checking bench for toy_inst_fetch: directed scenarios plus a randomized
// run checked against a stream-level model (expected PC sequence, outstanding count).
module tb_toy_inst_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_rd_data = '0;
    logic [31:0] mem_wr_data;
    logic [3:0]  mem_wr_byte_en;
    logic        mem_wr_en;
    logic        redirect_vld = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        inst_vld;
    logic        inst_rdy = 1'b1;
    logic [31:0] inst_pc;
    logic [31:0] inst_data;

    logic        w_mem_en;
    logic [31:0] w_mem_addr;
    logic [31:0] w_mem_rd_data = '0;
    logic [31:0] w_mem_wr_data;
    logic [3:0]  w_mem_wr_byte_en;
    logic        w_mem_wr_en;
    logic        w_redirect_vld = 1'b0;
    logic [31:0] w_redirect_pc = '0;
    logic        w_inst_vld;
    logic        w_inst_rdy = 1'b1;
    logic [31:0] w_inst_pc;
    logic [31:0] w_inst_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Memory word k holds A000_0000 + k, returned one cycle after the request.
    always @(posedge clk) if (mem_en)   mem_rd_data   <= 32'hA000_0000 + mem_addr;
    always @(posedge clk) if (w_mem_en) w_mem_rd_data <= 32'hA000_0000 + w_mem_addr;

    toy_inst_fetch u_dut (
        .clk(clk), .rst(rst),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .mem_wr_data(mem_wr_data), .mem_wr_byte_en(mem_wr_byte_en), .mem_wr_en(mem_wr_en),
        .redirect_vld(redirect_vld), .redirect_pc(redirect_pc),
        .inst_vld(inst_vld), .inst_rdy(inst_rdy), .inst_pc(inst_pc), .inst_data(inst_data)
    );

    toy_inst_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .rst(rst),
        .mem_en(w_mem_en), .mem_addr(w_mem_addr), .mem_rd_data(w_mem_rd_data),
        .mem_wr_data(w_mem_wr_data), .mem_wr_byte_en(w_mem_wr_byte_en), .mem_wr_en(w_mem_wr_en),
        .redirect_vld(w_redirect_vld), .redirect_pc(w_redirect_pc),
        .inst_vld(w_inst_vld), .inst_rdy(w_inst_rdy), .inst_pc(w_inst_pc), .inst_data(w_inst_data)
    );

    // Leaves the caller at the start of the first cycle after reset release.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; inst_rdy = 1'b1; redirect_vld = 1'b0; redirect_pc = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk); #1;
        n_checks++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL reset_mem_en: got %b want 0", mem_en); end
        n_checks++; if (inst_vld !== 1'b0) begin n_fail++; $display("FAIL reset_inst_vld: got %b want 0", inst_vld); end
        n_checks++; if (inst_pc !== 32'h0) begin n_fail++; $display("FAIL reset_inst_pc: got %h want 0", inst_pc); end
        n_checks++; if (inst_data !== 32'h0) begin n_fail++; $display("FAIL reset_inst_data: got %h want 0", inst_data); end
        n_checks++;
        if ({mem_wr_en, mem_wr_byte_en, mem_wr_data} !== 37'h0) begin
            n_fail++; $display("FAIL reset_wr_ports: got %b/%h/%h want 0", mem_wr_en, mem_wr_byte_en, mem_wr_data);
        end
    endtask

    task automatic test_stream();
        do_reset();
        #1;
        n_checks++; if (mem_en !== 1'b1 || mem_addr !== 32'h0) begin n_fail++; $display("FAIL stream_first_issue: got en=%b addr=%h want en=1 addr=0", mem_en, mem_addr); end
        n_checks++; if (inst_vld !== 1'b0) begin n_fail++; $display("FAIL stream_vld_c0: got %b want 0", inst_vld); end
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk); #1;
            n_checks++; if (mem_en !== 1'b1 || mem_addr !== 32'(c)) begin n_fail++; $display("FAIL stream_issue c=%0d: got en=%b addr=%h want en=1 addr=%h", c, mem_en, mem_addr, c); end
            n_checks++; if (inst_vld !== (c >= 2)) begin n_fail++; $display("FAIL stream_vld c=%0d: got %b want %b", c, inst_vld, c >= 2); end
            if (c >= 2) begin
                n_checks++;
                if (inst_pc !== 32'((c-2)*4) || inst_data !== 32'hA000_0000 + 32'(c-2)) begin
                    n_fail++; $display("FAIL stream_head c=%0d: got (%h,%h) want (%h,%h)", c, inst_pc, inst_data, 32'((c-2)*4), 32'hA000_0000 + 32'(c-2));
                end
            end
        end
    endtask

    // Continues the stream left by test_stream (head PC 0x24 in the next cycle).
    task automatic test_stall();
        @(negedge clk); inst_rdy = 1'b0;
        for (int s = 0; s < 6; s++) begin
            if (s > 0) @(negedge clk);
            #1;
            n_checks++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL stall_mem_en s=%0d: got %b want 0", s, mem_en); end
            n_checks++;
            if (inst_vld !== 1'b1 || inst_pc !== 32'h24 || inst_data !== 32'hA000_0009) begin
                n_fail++; $display("FAIL stall_head s=%0d: got vld=%b (%h,%h) want vld=1 (24,a0000009)", s, inst_vld, inst_pc, inst_data);
            end
        end
        @(negedge clk); inst_rdy = 1'b1; #1;
        n_checks++; if (mem_en !== 1'b1 || mem_addr !== 32'd11) begin n_fail++; $display("FAIL stall_resume_issue: got en=%b addr=%h want en=1 addr=b", mem_en, mem_addr); end
        for (int k = 0; k < 6; k++) begin
            if (k > 0) begin @(negedge clk); #1; end
            n_checks++;
            if (inst_vld !== 1'b1 || inst_pc !== 32'h24 + 32'(4*k) || inst_data !== 32'hA000_0009 + 32'(k)) begin
                n_fail++; $display("FAIL stall_resume_head k=%0d: got vld=%b (%h,%h) want (%h,%h)", k, inst_vld, inst_pc, inst_data, 32'h24 + 32'(4*k), 32'hA000_0009 + 32'(k));
            end
            n_checks++; if (mem_en !== 1'b1) begin n_fail++; $display("FAIL stall_resume_rate k=%0d: got en=%b want 1", k, mem_en); end
        end
    endtask

    task automatic test_redirect();
        do_reset();
        for (int c = 1; c <= 4; c++) @(negedge clk);
        #1;
        n_checks++; if (mem_en !== 1'b1 || mem_addr !== 32'h4) begin n_fail++; $display("FAIL redir_pre_issue: got en=%b addr=%h want en=1 addr=4", mem_en, mem_addr); end
        @(negedge clk); redirect_vld = 1'b1; redirect_pc = 32'h0000_0100; #1;
        n_checks++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL redir_mem_en: got %b want 0", mem_en); end
        @(negedge clk); redirect_vld = 1'b0; #1;
        n_checks++; if (inst_vld !== 1'b0) begin n_fail++; $display("FAIL redir_flush: got vld=%b want 0", inst_vld); end
        n_checks++; if (mem_en !== 1'b1 || mem_addr !== 32'h40) begin n_fail++; $display("FAIL redir_new_addr: got en=%b addr=%h want en=1 addr=40", mem_en, mem_addr); end
        @(negedge clk); #1;
        n_checks++; if (inst_vld !== 1'b0) begin n_fail++; $display("FAIL redir_gap: got vld=%b want 0", inst_vld); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            n_checks++;
            if (inst_vld !== 1'b1 || inst_pc !== 32'h100 + 32'(4*k) || inst_data !== 32'hA000_0040 + 32'(k)) begin
                n_fail++; $display("FAIL redir_stream k=%0d: got vld=%b (%h,%h) want (%h,%h)", k, inst_vld, inst_pc, inst_data, 32'h100 + 32'(4*k), 32'hA000_0040 + 32'(k));
            end
        end
    endtask

    task automatic test_redirect_unaligned();
        @(negedge clk); redirect_vld = 1'b1; redirect_pc = 32'h0000_0103; #1;
        @(negedge clk); redirect_vld = 1'b0; #1;
        n_checks++; if (mem_en !== 1'b1 || mem_addr !== 32'h40) begin n_fail++; $display("FAIL unal_addr: got en=%b addr=%h want en=1 addr=40", mem_en, mem_addr); end
        @(negedge clk); @(negedge clk); #1;
        n_checks++; if (inst_vld !== 1'b1 || inst_pc !== 32'h100) begin n_fail++; $display("FAIL unal_pc: got vld=%b pc=%h want vld=1 pc=100", inst_vld, inst_pc); end
    endtask

    task automatic test_back_to_back_redirect();
        @(negedge clk); redirect_vld = 1'b1; redirect_pc = 32'h0000_0200; #1;
        n_checks++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL b2b_en_1: got %b want 0", mem_en); end
        @(negedge clk); redirect_pc = 32'h0000_3007; #1;
        n_checks++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL b2b_en_2: got %b want 0", mem_en); end
        @(negedge clk); redirect_vld = 1'b0; #1;
        n_checks++; if (mem_en !== 1'b1 || mem_addr !== 32'hC01) begin n_fail++; $display("FAIL b2b_addr: got en=%b addr=%h want en=1 addr=c01", mem_en, mem_addr); end
        @(negedge clk); @(negedge clk); #1;
        n_checks++; if (inst_vld !== 1'b1 || inst_pc !== 32'h3004) begin n_fail++; $display("FAIL b2b_pc: got vld=%b pc=%h want vld=1 pc=3004", inst_vld, inst_pc); end
    endtask

    task automatic test_wrap();
        do_reset();
        #1;
        n_checks++; if (w_mem_en !== 1'b1 || w_mem_addr !== 32'h3FFF_FFFF) begin n_fail++; $display("FAIL wrap_addr0: got en=%b addr=%h want en=1 addr=3fffffff", w_mem_en, w_mem_addr); end
        @(negedge clk); #1;
        n_checks++; if (w_mem_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_addr1: got %h want 0", w_mem_addr); end
        @(negedge clk); #1;
        n_checks++;
        if (w_inst_vld !== 1'b1 || w_inst_pc !== 32'hFFFF_FFFC || w_inst_data !== 32'hDFFF_FFFF) begin
            n_fail++; $display("FAIL wrap_head0: got vld=%b (%h,%h) want (fffffffc,dfffffff)", w_inst_vld, w_inst_pc, w_inst_data);
        end
        @(negedge clk); #1;
        n_checks++;
        if (w_inst_vld !== 1'b1 || w_inst_pc !== 32'h0 || w_inst_data !== 32'hA000_0000) begin
            n_fail++; $display("FAIL wrap_head1: got vld=%b (%h,%h) want (0,a0000000)", w_inst_vld, w_inst_pc, w_inst_data);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int c = 0; c < 5; c++) @(negedge clk);
        #1;
        n_checks++; if (inst_vld !== 1'b1) begin n_fail++; $display("FAIL areset_pre_vld: got %b want 1", inst_vld); end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (inst_vld !== 1'b0 || mem_en !== 1'b0 || inst_pc !== 32'h0 || inst_data !== 32'h0) begin
            n_fail++; $display("FAIL areset_immediate: got vld=%b en=%b pc=%h data=%h want all 0", inst_vld, mem_en, inst_pc, inst_data);
        end
        @(negedge clk); rst = 1'b0; #1;
        n_checks++; if (mem_en !== 1'b1 || mem_addr !== 32'h0) begin n_fail++; $display("FAIL areset_restart: got en=%b addr=%h want en=1 addr=0", mem_en, mem_addr); end
        @(negedge clk); @(negedge clk); #1;
        n_checks++;
        if (inst_vld !== 1'b1 || inst_pc !== 32'h0 || inst_data !== 32'hA000_0000) begin
            n_fail++; $display("FAIL areset_first_head: got vld=%b (%h,%h) want (0,a0000000)", inst_vld, inst_pc, inst_data);
        end
    endtask

    // Model: expected head PC, next fetch PC, words outstanding since the last
    // redirect, and whether the previous cycle issued (that word is not yet visible).
    task automatic test_random();
        logic [31:0] exp_pc, exp_fetch;
        int          outst, issued_prev;
        logic        exp_vld, pop_m, exp_en;
        exp_pc = '0; exp_fetch = '0; outst = 0; issued_prev = 0;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i > 0) @(negedge clk);
            inst_rdy     = ($urandom_range(0, 99) < 70);
            redirect_vld = ($urandom_range(0, 99) < 4);
            redirect_pc  = $urandom();
            #1;
            exp_vld = (outst - issued_prev) != 0;
            pop_m   = exp_vld && inst_rdy && !redirect_vld;
            exp_en  = !redirect_vld && ((outst - int'(pop_m)) < 2);
            n_checks++; if (inst_vld !== exp_vld) begin n_fail++; $display("FAIL rand_vld i=%0d: got %b want %b", i, inst_vld, exp_vld); end
            n_checks++; if (mem_en !== exp_en) begin n_fail++; $display("FAIL rand_mem_en i=%0d: got %b want %b", i, mem_en, exp_en); end
            if (exp_en) begin
                n_checks++; if (mem_addr !== {2'b00, exp_fetch[31:2]}) begin n_fail++; $display("FAIL rand_addr i=%0d: got %h want %h", i, mem_addr, {2'b00, exp_fetch[31:2]}); end
            end
            if (exp_vld) begin
                n_checks++;
                if (inst_pc !== exp_pc || inst_data !== 32'hA000_0000 + {2'b00, exp_pc[31:2]}) begin
                    n_fail++; $display("FAIL rand_head i=%0d: got (%h,%h) want (%h,%h)", i, inst_pc, inst_data, exp_pc, 32'hA000_0000 + {2'b00, exp_pc[31:2]});
                end
            end
            if (redirect_vld) begin
                exp_pc = {redirect_pc[31:2], 2'b00}; exp_fetch = exp_pc; outst = 0; issued_prev = 0;
            end else begin
                if (pop_m) begin exp_pc = exp_pc + 32'd4; outst--; end
                if (exp_en) begin exp_fetch = exp_fetch + 32'd4; outst++; end
                issued_prev = int'(exp_en);
            end
        end
        @(negedge clk); redirect_vld = 1'b0; inst_rdy = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within bound");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_redirect_unaligned();
        test_back_to_back_redirect();
        test_wrap();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
